mult_hilo_sequencer: RTL and testbench

Multi-cycle multiply/accumulate sequencer that owns the HI/LO register pair for the MULT, MULTU, MADD and MSUB operations of the 32-bit datapath. It lives beside ALU32Bit and takes these long operations off the single-cycle ALU. It runs a fixed-latency radix-2 shift-add multiply, then applies the sign fix-up and the accumulate/subtract against HI/LO. A Start/Busy/Done handshake lets the pipeline controller stall while the unit is working.

---
 rtl/mult_hilo_sequencer.sv | 101 ++++++++++
 tb/tb_mult_hilo_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mult_hilo_sequencer.sv
// HI/LO owner for MULT/MULTU/MADD/MSUB: 32-step radix-2 shift-add multiply, then a
// sign fix-up and optional accumulate/subtract against HI/LO, with a Start/Busy/Done handshake.
module mult_hilo_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             HiWrite,
   input  logic             LoWrite,
   input  logic [WIDTH-1:0] WData,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StMul, StFix} state_e;

   state_e               state;
   logic [1:0]           op_q;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     mplier;
   logic [2*WIDTH-1:0]   prod;
   logic                 sign;
   logic [CW-1:0]        cnt;

   logic                 signed_op;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   fixed;
   logic [2*WIDTH-1:0]   result;

   // Magnitude of the most negative value wraps to itself and is treated as unsigned.
   always_comb begin
      signed_op = (Op != 2'b01);
      a_mag     = (signed_op && A[WIDTH-1]) ? -A : A;
      b_mag     = (signed_op && B[WIDTH-1]) ? -B : B;
      sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
      fixed     = sign ? -prod : prod;
      unique case (op_q)
         2'b10:   result = {HI, LO} + fixed;
         2'b11:   result = {HI, LO} - fixed;
         default: result = fixed;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state  <= StIdle;
         op_q   <= '0;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
         sign   <= 1'b0;
         cnt    <= '0;
         Busy   <= 1'b0;
         Done   <= 1'b0;
         HI     <= '0;
         LO     <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               Done <= 1'b0;
               if (HiWrite) HI <= WData;
               if (LoWrite) LO <= WData;
               if (Start) begin
                  op_q   <= Op;
                  mcand  <= a_mag;
                  mplier <= b_mag;
                  sign   <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
                  prod   <= '0;
                  cnt    <= '0;
                  Busy   <= 1'b1;
                  state  <= StMul;
               end
            end
            StMul: begin
               prod   <= {sum, prod[WIDTH-1:1]};
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) state <= StFix;
            end
            StFix: begin
               {HI, LO} <= result;
               Done     <= 1'b1;
               Busy     <= 1'b0;
               state    <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_hilo_sequencer.sv
// Bench for mult_hilo_sequencer: directed cases plus random operations against a 64-bit
// arithmetic reference of HI/LO.
module tb_mult_hilo_sequencer;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        Start = 1'b0;
   logic [1:0]  Op = '0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        HiWrite = 1'b0;
   logic        LoWrite = 1'b0;
   logic [31:0] WData = '0;
   logic        Busy;
   logic        Done;
   logic [31:0] HI;
   logic [31:0] LO;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] acc = '0;
   logic [1:0]  pend_op;
   logic [31:0] pend_a;
   logic [31:0] pend_b;

   mult_hilo_sequencer #(.WIDTH(32)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
      .HiWrite(HiWrite), .LoWrite(LoWrite), .WData(WData),
      .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
   );

   always #5 Clk = ~Clk;

   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] hl);
      logic [63:0] p;
      longint      sa;
      longint      sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op == 2'b01) p = {32'b0, a} * {32'b0, b};
      else p = 64'(sa * sb);
      case (op)
         2'b10:   return hl + p;
         2'b11:   return hl - p;
         default: return p;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Optional MTHI/MTLO in the accepting cycle; they land before the op reads HI/LO.
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic hw, input logic lw, input logic [31:0] wd);
      Start = 1'b1; Op = op; A = a; B = b;
      HiWrite = hw; LoWrite = lw; WData = wd;
      if (hw) acc[63:32] = wd;
      if (lw) acc[31:0] = wd;
      pend_op = op; pend_a = a; pend_b = b;
      tick();
      Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int already);
      int n;
      int busy_low;
      n = already;
      busy_low = 0;
      while (!Done && n < 45) begin
         if (!Busy) busy_low++;
         tick();
         n++;
      end
      acc = ref_result(pend_op, pend_a, pend_b, acc);
      chk({tag, "_latency"}, 64'(n), 64'd33);
      chk({tag, "_busy_low"}, 64'(busy_low), 64'd0);
      chk({tag, "_busy_done"}, {63'b0, Busy}, 64'd0);
      chk({tag, "_hilo"}, {HI, LO}, acc);
   endtask

   initial begin
      int dn;
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rhw;
      logic        rlw;

      tick();
      tick();
      chk("rst_hilo", {HI, LO}, 64'd0);
      chk("rst_busy_done", {62'b0, Busy, Done}, 64'd0);
      Rst = 1'b1;
      tick();

      start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
      wait_done("multu_max", 0);
      chk("multu_max_const", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
      chk("done_in_cycle", {63'b0, Done}, 64'd1);
      tick();
      chk("done_one_cycle", {63'b0, Done}, 64'd0);

      start_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, '0);
      wait_done("mult_neg", 0);
      chk("mult_neg_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFF1);
      start_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '0);
      wait_done("mult_min", 0);
      chk("mult_min_const", {HI, LO}, 64'h4000_0000_0000_0000);

      LoWrite = 1'b1; WData = 32'hFFFF_FFFF; tick();
      LoWrite = 1'b0; HiWrite = 1'b1; WData = 32'h0; tick();
      HiWrite = 1'b0;
      acc = 64'h0000_0000_FFFF_FFFF;
      chk("mt_write", {HI, LO}, acc);
      start_op(2'b10, 32'd1, 32'd1, 1'b0, 1'b0, '0);
      wait_done("madd", 0);
      chk("madd_const", {HI, LO}, 64'h0000_0001_0000_0000);

      HiWrite = 1'b1; LoWrite = 1'b1; WData = 32'h0; tick();
      HiWrite = 1'b0; LoWrite = 1'b0;
      acc = '0;
      start_op(2'b11, 32'd1, 32'd1, 1'b0, 1'b0, '0);
      wait_done("msub", 0);
      chk("msub_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);

      start_op(2'b10, 32'hFFFF_FFF0, 32'd7, 1'b1, 1'b0, 32'h0000_0100);
      wait_done("madd_accept_write", 0);

      start_op(2'b00, 32'd3, 32'd4, 1'b0, 1'b0, '0);
      repeat (4) tick();
      Start = 1'b1; Op = 2'b01; A = 32'd2; B = 32'd2; tick();
      Start = 1'b0;
      repeat (4) tick();
      HiWrite = 1'b1; WData = 32'h1234; tick();
      HiWrite = 1'b0;
      wait_done("ignored_inputs", 10);
      chk("ignored_const", {HI, LO}, 64'd12);
      dn = 0;
      repeat (40) begin
         tick();
         if (Done) dn++;
      end
      chk("single_done", 64'(dn), 64'd0);

      start_op(2'b01, 32'd7, 32'd9, 1'b0, 1'b0, '0);
      repeat (9) tick();
      Rst = 1'b0;
      #1;
      acc = '0;
      chk("midrst_hilo", {HI, LO}, 64'd0);
      chk("midrst_busy", {63'b0, Busy}, 64'd0);
      tick();
      Rst = 1'b1;
      dn = 0;
      repeat (40) begin
         tick();
         if (Done || Busy) dn++;
      end
      chk("midrst_no_done", 64'(dn), 64'd0);
      start_op(2'b01, 32'd7, 32'd9, 1'b0, 1'b0, '0);
      wait_done("after_rst", 0);
      chk("after_rst_const", {HI, LO}, 64'd63);

      start_op(2'b01, 32'd5, 32'd5, 1'b0, 1'b0, '0);
      wait_done("b2b_first", 0);
      chk("b2b_first_lo", {32'b0, LO}, 64'd25);
      start_op(2'b01, 32'd2, 32'd3, 1'b0, 1'b0, '0);
      wait_done("b2b_second", 0);
      chk("b2b_second_lo", {32'b0, LO}, 64'd6);

      for (int i = 0; i < 14; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         if (i % 4 == 0) ra = {1'b1, 31'($urandom_range(0, 3))};
         rhw = ($urandom_range(0, 3) == 0);
         rlw = ($urandom_range(0, 3) == 0);
         start_op(rop, ra, rb, rhw, rlw, $urandom);
         wait_done("rand", 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
